// File: rtl/axi_lite_to_reg_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_to_reg_pkg
// Shared definitions for the AXI4-Lite to register-interface bridge:
//   - bridge FSM state encoding
//   - AXI response codes and the error-to-response mapping helper
//   - default register-interface request/response structs (32-bit address,
//     32-bit data), matching the register-interface stages downstream
// -----------------------------------------------------------------------------
package axi_lite_to_reg_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 32;
  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_STRB_WIDTH = REG_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    RD_REQ = 3'd2,
    WR_RSP = 3'd3,
    RD_RSP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [REG_DATA_WIDTH-1:0] wdata;
    logic [REG_STRB_WIDTH-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                      ready;
    logic [REG_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } reg_rsp_t;

  // Register-interface error flag to AXI response code.
  function automatic logic [1:0] err_to_resp(input logic err);
    if (err) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axi_lite_to_reg.sv
// -----------------------------------------------------------------------------
// axi_lite_to_reg
// AXI4-Lite slave to register-interface bridge. Accepts one AXI read or write
// at a time, issues it as a single register-interface transaction, and returns
// the completion on B or R. Register-interface errors map to SLVERR.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   awaddr_i/awvalid_i/awready_o  AXI write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o  AXI write data channel
//   bresp_o/bvalid_o/bready_i     AXI write response channel
//   araddr_i/arvalid_i/arready_o  AXI read address channel
//   rdata_o/rresp_o/rvalid_o/rready_i  AXI read data channel
//   reg_req_o                     register request (fully registered)
//   reg_rsp_i                     register response
// -----------------------------------------------------------------------------
module axi_lite_to_reg
  import axi_lite_to_reg_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter type reg_req_t = axi_lite_to_reg_pkg::reg_req_t,
  parameter type reg_rsp_t = axi_lite_to_reg_pkg::reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  input  logic [AddrWidth-1:0]   araddr_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output reg_req_t               reg_req_o,
  input  reg_rsp_t               reg_rsp_i
);

  if ((DataWidth != 32) && (DataWidth != 64)) begin : g_bad_data_width
    $error("axi_lite_to_reg: DataWidth must be 32 or 64");
  end

  state_e                 state_r;
  state_e                 state_s;
  logic                   prio_rd_r;   // 0: write wins a tie, 1: read wins
  logic                   wr_elig_s;
  logic                   rd_elig_s;
  logic                   wr_grant_s;
  logic                   rd_grant_s;
  reg_req_t               req_r;
  logic                   bvalid_r;
  logic [1:0]             bresp_r;
  logic                   rvalid_r;
  logic [1:0]             rresp_r;
  logic [DataWidth-1:0]   rdata_r;

  // A write needs both AW and W present; AW or W alone is never taken.
  assign wr_elig_s = awvalid_i & wvalid_i;
  assign rd_elig_s = arvalid_i;

  // Next-state and grant decode.
  always_comb begin
    state_s    = state_r;
    wr_grant_s = 1'b0;
    rd_grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_elig_s && (!rd_elig_s || !prio_rd_r)) begin
          wr_grant_s = 1'b1;
          state_s    = WR_REQ;
        end else if (rd_elig_s) begin
          rd_grant_s = 1'b1;
          state_s    = RD_REQ;
        end else begin
          state_s    = IDLE;
        end
      end
      WR_REQ: begin
        if (reg_rsp_i.ready) begin
          state_s = WR_RSP;
        end else begin
          state_s = WR_REQ;
        end
      end
      RD_REQ: begin
        if (reg_rsp_i.ready) begin
          state_s = RD_RSP;
        end else begin
          state_s = RD_REQ;
        end
      end
      WR_RSP: begin
        if (bready_i) begin
          state_s = IDLE;
        end else begin
          state_s = WR_RSP;
        end
      end
      RD_RSP: begin
        if (rready_i) begin
          state_s = IDLE;
        end else begin
          state_s = RD_RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, arbitration priority, register request and AXI response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      prio_rd_r <= 1'b0;
      req_r     <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      rvalid_r  <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= '0;
    end else begin
      state_r <= state_s;
      if (wr_grant_s || rd_grant_s) begin
        prio_rd_r <= ~prio_rd_r;
      end
      case (state_r)
        IDLE: begin
          if (wr_grant_s) begin
            req_r.valid <= 1'b1;
            req_r.addr  <= awaddr_i;
            req_r.write <= 1'b1;
            req_r.wdata <= wdata_i;
            req_r.wstrb <= wstrb_i;
          end else if (rd_grant_s) begin
            req_r.valid <= 1'b1;
            req_r.addr  <= araddr_i;
            req_r.write <= 1'b0;
            req_r.wdata <= '0;
            req_r.wstrb <= '0;
          end
        end
        WR_REQ: begin
          if (reg_rsp_i.ready) begin
            req_r    <= '0;
            bvalid_r <= 1'b1;
            bresp_r  <= err_to_resp(reg_rsp_i.error);
          end
        end
        RD_REQ: begin
          if (reg_rsp_i.ready) begin
            req_r    <= '0;
            rvalid_r <= 1'b1;
            rresp_r  <= err_to_resp(reg_rsp_i.error);
            rdata_r  <= reg_rsp_i.rdata;
          end
        end
        WR_RSP: begin
          if (bready_i) begin
            bvalid_r <= 1'b0;
          end
        end
        RD_RSP: begin
          if (rready_i) begin
            rvalid_r <= 1'b0;
          end
        end
        default: begin
          req_r    <= '0;
          bvalid_r <= 1'b0;
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

  // Readies are combinational from IDLE and the grant; held low during reset
  // so nothing is accepted while the bridge is being cleared.
  assign awready_o = wr_grant_s & ~rst_i;
  assign wready_o  = wr_grant_s & ~rst_i;
  assign arready_o = rd_grant_s & ~rst_i;

  assign bvalid_o  = bvalid_r;
  assign bresp_o   = bresp_r;
  assign rvalid_o  = rvalid_r;
  assign rresp_o   = rresp_r;
  assign rdata_o   = rdata_r;
  assign reg_req_o = req_r;

endmodule

// File: tb/tb_axi_lite_to_reg.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_to_reg
// Directed testbench for axi_lite_to_reg. Inputs are driven 1 time unit after
// the rising edge and outputs sampled 1 time unit later, well away from the
// next rising edge.
// -----------------------------------------------------------------------------
module tb_axi_lite_to_reg;
  import axi_lite_to_reg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] awaddr_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  reg_req_t    reg_req_o;
  reg_rsp_t    reg_rsp_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  axi_lite_to_reg #(.AddrWidth(32), .DataWidth(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .araddr_i  (araddr_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .reg_req_o (reg_req_o),
    .reg_rsp_i (reg_rsp_i)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Move from the drive point to the sample point.
  task automatic settle();
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_awready"}, awready_o, 1'b0);
    check_eq({tag, "_wready"},  wready_o,  1'b0);
    check_eq({tag, "_arready"}, arready_o, 1'b0);
    check_eq({tag, "_bvalid"},  bvalid_o,  1'b0);
    check_eq({tag, "_rvalid"},  rvalid_o,  1'b0);
    check_eq({tag, "_bresp"},   bresp_o,   2'b00);
    check_eq({tag, "_rresp"},   rresp_o,   2'b00);
    check_eq({tag, "_rdata"},   rdata_o,   32'h0);
    check_eq({tag, "_req"},     reg_req_o, '0);
  endtask

  initial begin
    rst_i     = 1'b1;
    awaddr_i  = 32'h0;
    awvalid_i = 1'b0;
    wdata_i   = 32'h0;
    wstrb_i   = 4'h0;
    wvalid_i  = 1'b0;
    bready_i  = 1'b1;
    araddr_i  = 32'h0;
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    reg_rsp_i = '0;

    // ---------------- reset state ----------------
    next_cycle();
    settle();
    check_idle_outputs("rst");
    next_cycle();
    rst_i = 1'b0;

    // ---------------- single write ----------------
    next_cycle();
    awaddr_i = 32'h0000_0010; awvalid_i = 1'b1;
    wdata_i  = 32'hDEAD_BEEF; wstrb_i = 4'hF; wvalid_i = 1'b1;
    settle();
    check_eq("wr_awready", awready_o, 1'b1);
    check_eq("wr_wready",  wready_o,  1'b1);
    check_eq("wr_arready", arready_o, 1'b0);
    next_cycle();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    settle();
    check_eq("wr_req_valid1", reg_req_o.valid, 1'b1);
    check_eq("wr_req_write",  reg_req_o.write, 1'b1);
    check_eq("wr_req_addr",   reg_req_o.addr,  32'h0000_0010);
    check_eq("wr_req_wdata",  reg_req_o.wdata, 32'hDEAD_BEEF);
    check_eq("wr_req_wstrb",  reg_req_o.wstrb, 4'hF);
    check_eq("wr_awready_busy", awready_o, 1'b0);
    next_cycle();
    reg_rsp_i.ready = 1'b1; reg_rsp_i.error = 1'b0;
    settle();
    check_eq("wr_req_valid2", reg_req_o.valid, 1'b1);
    check_eq("wr_req_addr2",  reg_req_o.addr,  32'h0000_0010);
    check_eq("wr_bvalid_early", bvalid_o, 1'b0);
    next_cycle();
    reg_rsp_i.ready = 1'b0;
    settle();
    check_eq("wr_req_drop", reg_req_o.valid, 1'b0);
    check_eq("wr_bvalid",   bvalid_o, 1'b1);
    check_eq("wr_bresp",    bresp_o,  2'b00);
    next_cycle();
    settle();
    check_eq("wr_bvalid_clr", bvalid_o, 1'b0);

    // ---------------- single read with error ----------------
    next_cycle();
    araddr_i = 32'h0000_0020; arvalid_i = 1'b1;
    settle();
    check_eq("rd_arready", arready_o, 1'b1);
    check_eq("rd_awready", awready_o, 1'b0);
    next_cycle();
    arvalid_i = 1'b0;
    reg_rsp_i.ready = 1'b1; reg_rsp_i.rdata = 32'h1234_5678; reg_rsp_i.error = 1'b1;
    settle();
    check_eq("rd_req_valid", reg_req_o.valid, 1'b1);
    check_eq("rd_req_write", reg_req_o.write, 1'b0);
    check_eq("rd_req_addr",  reg_req_o.addr,  32'h0000_0020);
    check_eq("rd_req_wstrb", reg_req_o.wstrb, 4'h0);
    check_eq("rd_req_wdata", reg_req_o.wdata, 32'h0);
    next_cycle();
    reg_rsp_i = '0;
    settle();
    check_eq("rd_rvalid", rvalid_o, 1'b1);
    check_eq("rd_rdata",  rdata_o,  32'h1234_5678);
    check_eq("rd_rresp",  rresp_o,  2'b10);
    check_eq("rd_req_drop", reg_req_o.valid, 1'b0);
    next_cycle();
    settle();
    check_eq("rd_rvalid_clr", rvalid_o, 1'b0);

    // ---------------- simultaneous AW+W+AR from reset ----------------
    rst_i = 1'b1;
    next_cycle();
    awaddr_i = 32'h0000_0100; wdata_i = 32'hA5A5_0001; wstrb_i = 4'h3;
    araddr_i = 32'h0000_0200;
    awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
    reg_rsp_i.ready = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) next_cycle();
      settle();
      check_eq($sformatf("arb_aw_%0d", i), awready_o, (i % 6) == 0);
      check_eq($sformatf("arb_w_%0d", i),  wready_o,  (i % 6) == 0);
      check_eq($sformatf("arb_ar_%0d", i), arready_o, (i % 6) == 3);
      if ((i % 3) == 1) begin
        check_eq($sformatf("arb_write_%0d", i), reg_req_o.write, (i % 6) == 1);
        check_eq($sformatf("arb_addr_%0d", i), reg_req_o.addr,
                 ((i % 6) == 1) ? 32'h0000_0100 : 32'h0000_0200);
      end
    end
    next_cycle();
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    settle();
    check_eq("arb_end_idle", reg_req_o.valid, 1'b0);

    // ---------------- AW without W ----------------
    next_cycle();
    awaddr_i = 32'h0000_0040; awvalid_i = 1'b1; wdata_i = 32'h0000_0077; wstrb_i = 4'h1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) next_cycle();
      settle();
      check_eq($sformatf("aw_only_awready_%0d", i), awready_o, 1'b0);
      check_eq($sformatf("aw_only_wready_%0d", i),  wready_o,  1'b0);
    end
    next_cycle();
    wvalid_i = 1'b1;
    settle();
    check_eq("aw_w_awready", awready_o, 1'b1);
    check_eq("aw_w_wready",  wready_o,  1'b1);
    next_cycle();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    settle();
    check_eq("aw_w_req_addr", reg_req_o.addr, 32'h0000_0040);
    next_cycle();
    settle();
    check_eq("aw_w_bvalid", bvalid_o, 1'b1);
    next_cycle();

    // ---------------- B backpressure ----------------
    bready_i = 1'b0;
    awaddr_i = 32'h0000_0080; wdata_i = 32'h5555_AAAA; wstrb_i = 4'hC;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    reg_rsp_i.ready = 1'b1; reg_rsp_i.error = 1'b1;
    settle();
    check_eq("bp_grant", awready_o, 1'b1);
    next_cycle();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    araddr_i = 32'h0000_00C0; arvalid_i = 1'b1;
    settle();
    check_eq("bp_ar_in_req", arready_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      reg_rsp_i.error = 1'b0;
      settle();
      check_eq($sformatf("bp_bvalid_%0d", i), bvalid_o, 1'b1);
      check_eq($sformatf("bp_bresp_%0d", i),  bresp_o,  2'b10);
      check_eq($sformatf("bp_arready_%0d", i), arready_o, 1'b0);
    end
    next_cycle();
    bready_i = 1'b1;
    settle();
    check_eq("bp_bvalid_hs", bvalid_o, 1'b1);
    check_eq("bp_arready_hs", arready_o, 1'b0);
    next_cycle();
    settle();
    check_eq("bp_bvalid_clr", bvalid_o, 1'b0);
    check_eq("bp_ar_accept", arready_o, 1'b1);
    next_cycle();
    arvalid_i = 1'b0;
    reg_rsp_i.rdata = 32'hCAFE_F00D; reg_rsp_i.error = 1'b0;
    settle();
    check_eq("bp_rd_addr", reg_req_o.addr, 32'h0000_00C0);
    next_cycle();
    reg_rsp_i = '0;
    settle();
    check_eq("bp_rvalid", rvalid_o, 1'b1);
    check_eq("bp_rdata",  rdata_o,  32'hCAFE_F00D);
    check_eq("bp_rresp",  rresp_o,  2'b00);
    next_cycle();

    // ---------------- reset during WR_REQ ----------------
    awaddr_i = 32'h0000_0300; wdata_i = 32'h0BAD_0BAD; wstrb_i = 4'hF;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    settle();
    check_eq("rr_grant", awready_o, 1'b1);
    next_cycle();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    settle();
    check_eq("rr_req_valid", reg_req_o.valid, 1'b1);
    next_cycle();
    rst_i = 1'b1;
    settle();
    check_eq("rr_req_async", reg_req_o.valid, 1'b0);
    next_cycle();
    settle();
    check_idle_outputs("rr");
    next_cycle();
    rst_i = 1'b0;
    reg_rsp_i.ready = 1'b1;
    settle();
    check_eq("rr_no_bvalid", bvalid_o, 1'b0);
    next_cycle();
    araddr_i = 32'h0000_0044; arvalid_i = 1'b1;
    reg_rsp_i.rdata = 32'h0F0F_1234;
    settle();
    check_eq("rr_rd_arready", arready_o, 1'b1);
    next_cycle();
    arvalid_i = 1'b0;
    settle();
    check_eq("rr_rd_addr", reg_req_o.addr, 32'h0000_0044);
    next_cycle();
    settle();
    check_eq("rr_rvalid", rvalid_o, 1'b1);
    check_eq("rr_rdata",  rdata_o,  32'h0F0F_1234);
    check_eq("rr_rresp",  rresp_o,  2'b00);
    next_cycle();
    settle();
    check_eq("rr_rvalid_clr", rvalid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
